ctrl_spi_tx: RTL



---
 rtl/ctrl_spi_tx_pkg.sv | 27 ++
 rtl/ctrl_spi_tx_if.sv | 37 +++
 rtl/ctrl_spi_tx_spi_bit_shifter.sv | 41 ++++
 rtl/ctrl_spi_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_spi_tx_pkg.sv
// rtl/ctrl_spi_tx_pkg.sv - shared types and constants for the control-word SPI link
//
// Holds the transmitter state encoding, the frame geometry and the SPI mode
// that both ends of the control-word link must agree on.

package ctrl_spi_tx_pkg;

    localparam int WORD_BITS = 16;
    localparam int NUM_WORDS = 5;

    // SPI mode 0: SCK idles low, data sampled on the SCK rising edge.
    localparam logic [1:0] SPI_MODE = 2'd0;
    localparam logic       SPI_CPOL = SPI_MODE[1];
    localparam logic       SPI_CPHA = SPI_MODE[0];

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_BIT_LO = 3'd2,
        ST_BIT_HI = 3'd3,
        ST_GAP    = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

endpackage

// File: rtl/ctrl_spi_tx_if.sv
// rtl/ctrl_spi_tx_if.sv - frame request and SPI bus signals of the control-word transmitter
//
// Signals:
//   start        single-cycle frame request
//   data0..data4 words to send, data0 first
//   busy, done   frame status (done is a one-cycle pulse)
//   spi_cs       chip select, active low
//   spi_clock    SCK, idle low
//   spi_data     MOSI, MSB first
// Modports: master = frame requester, slave = transmitter.

interface ctrl_spi_tx_if;
    import ctrl_spi_tx_pkg::*;

    logic  start;
    word_t data0;
    word_t data1;
    word_t data2;
    word_t data3;
    word_t data4;
    logic  busy;
    logic  done;
    logic  spi_cs;
    logic  spi_clock;
    logic  spi_data;

    modport master (
        output start, data0, data1, data2, data3, data4,
        input  busy, done, spi_cs, spi_clock, spi_data
    );

    modport slave (
        input  start, data0, data1, data2, data3, data4,
        output busy, done, spi_cs, spi_clock, spi_data
    );

endinterface

// File: rtl/ctrl_spi_tx_spi_bit_shifter.sv
// rtl/ctrl_spi_tx_spi_bit_shifter.sv - 16-bit MSB-first load/shift register with empty flag
//
// Ports:
//   i_Clock, i_Reset  clock, synchronous active-high reset
//   load, load_data   parallel load (takes priority over shift)
//   shift             move the next bit up to the MSB
//   msb               bit currently presented
//   empty             high while the last bit (original bit 0) is presented

module spi_bit_shifter
    import ctrl_spi_tx_pkg::*;
(
    input  logic  i_Clock,
    input  logic  i_Reset,
    input  logic  load,
    input  word_t load_data,
    input  logic  shift,
    output logic  msb,
    output logic  empty
);

    word_t      shift_reg;
    logic [3:0] bit_idx;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            shift_reg <= '0;
            bit_idx   <= 4'd0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_idx   <= 4'(WORD_BITS - 1);
        end else if (shift && bit_idx != 4'd0) begin
            shift_reg <= {shift_reg[WORD_BITS-2:0], 1'b0};
            bit_idx   <= bit_idx - 4'd1;
        end
    end

    assign msb   = shift_reg[WORD_BITS-1];
    assign empty = (bit_idx == 4'd0);

endmodule

// File: rtl/ctrl_spi_tx.sv
// rtl/ctrl_spi_tx.sv - SPI mode-0 master sending a frame of five 16-bit control words
//
// Ports:
//   i_Clock  system clock
//   i_Reset  synchronous active-high reset; aborts a frame in flight
//   bus      ctrl_spi_tx_if.slave: start/data0..4 in, busy/done/spi_cs/spi_clock/spi_data out
// Parameters: CLK_DIV (clocks per SCK half-period), CS_SETUP, WORD_GAP, CS_HOLD.
// Build option: CTRL_SPI_TX_CHECKSUM_EN appends a sixth word, the wrapping
// 16-bit sum of data0..data4 taken when the frame is latched.

module ctrl_spi_tx
    import ctrl_spi_tx_pkg::*;
#(
    parameter int CLK_DIV  = 12,
    parameter int CS_SETUP = 8,
    parameter int WORD_GAP = 8,
    parameter int CS_HOLD  = 8
) (
    input  logic         i_Clock,
    input  logic         i_Reset,
    ctrl_spi_tx_if.slave bus
);

`ifdef CTRL_SPI_TX_CHECKSUM_EN
    localparam int NUM_TX = NUM_WORDS + 1;
`else
    localparam int NUM_TX = NUM_WORDS;
`endif

    state_t     state;
    state_t     next_state;
    logic [7:0] phase;
    logic [2:0] word_idx;
    word_t      frame [NUM_TX];

    logic  accept;
    logic  phase_last;
    logic  word_last;
    logic  shift_bit;
    logic  word_inc;
    logic  sh_load;
    word_t sh_load_data;
    logic  sh_msb;
    logic  sh_empty;

    logic busy_q;
    logic done_q;
    logic cs_q;
    logic sck_q;
    logic mosi_q;

    // Phase counter preload for a state, counted down to zero.
    function automatic logic [7:0] phase_init(input state_t s);
        case (s)
            ST_SETUP:            return 8'(CS_SETUP - 1);
            ST_BIT_LO, ST_BIT_HI: return 8'(CLK_DIV - 1);
            ST_GAP:              return 8'(WORD_GAP - 1);
            ST_HOLD:             return 8'(CS_HOLD - 1);
            default:             return 8'd0;
        endcase
    endfunction

    // Outputs are registered one clock behind the state, so busy_q/done_q
    // still reflect the previous frame in the first IDLE cycles; blocking on
    // them keeps a start coincident with done from being taken.
    assign accept     = (state == ST_IDLE) && bus.start && !busy_q && !done_q;
    assign phase_last = (phase == 8'd0);
    assign word_last  = (word_idx == 3'(NUM_TX - 1));

    always_comb begin
        next_state = state;
        shift_bit  = 1'b0;
        word_inc   = 1'b0;
        case (state)
            ST_IDLE:   if (accept)     next_state = ST_SETUP;
            ST_SETUP:  if (phase_last) next_state = ST_BIT_LO;
            ST_BIT_LO: if (phase_last) next_state = ST_BIT_HI;
            ST_BIT_HI: begin
                if (phase_last) begin
                    if (!sh_empty) begin
                        shift_bit  = 1'b1;
                        next_state = ST_BIT_LO;
                    end else if (!word_last) begin
                        word_inc   = 1'b1;
                        next_state = (WORD_GAP == 0) ? ST_BIT_LO : ST_GAP;
                    end else begin
                        next_state = ST_HOLD;
                    end
                end
            end
            ST_GAP:    if (phase_last) next_state = ST_BIT_LO;
            ST_HOLD:   if (phase_last) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Every transition changes state, so a state change is exactly a state entry.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= ST_IDLE;
            phase <= 8'd0;
        end else begin
            state <= next_state;
            if (next_state != state)
                phase <= phase_init(next_state);
            else if (state != ST_IDLE)
                phase <= phase - 8'd1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (accept) begin
            frame[0] <= bus.data0;
            frame[1] <= bus.data1;
            frame[2] <= bus.data2;
            frame[3] <= bus.data3;
            frame[4] <= bus.data4;
`ifdef CTRL_SPI_TX_CHECKSUM_EN
            frame[NUM_WORDS] <= bus.data0 + bus.data1 + bus.data2 + bus.data3 + bus.data4;
`endif
        end
    end

    // The first word goes straight from the inputs so MOSI is valid in SETUP.
    assign sh_load      = accept || word_inc;
    assign sh_load_data = accept ? bus.data0 : frame[word_idx + 3'd1];

    spi_bit_shifter u_shifter (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .load      (sh_load),
        .load_data (sh_load_data),
        .shift     (shift_bit),
        .msb       (sh_msb),
        .empty     (sh_empty)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            word_idx <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= 1'b1;
            sck_q    <= SPI_CPOL;
            mosi_q   <= 1'b0;
        end else begin
            if (accept)
                word_idx <= 3'd0;
            else if (word_inc)
                word_idx <= word_idx + 3'd1;
            busy_q <= (state != ST_IDLE);
            cs_q   <= (state == ST_IDLE);
            sck_q  <= (state == ST_BIT_HI);
            mosi_q <= (state == ST_IDLE) ? 1'b0 : sh_msb;
            // cs_q still low here only on the first IDLE cycle after HOLD.
            done_q <= (state == ST_IDLE) && !cs_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.spi_cs    = cs_q;
    assign bus.spi_clock = sck_q;
    assign bus.spi_data  = mosi_q;

endmodule
